// File: rtl/b16_sram_arb.sv
// Two-port arbiter for an asynchronous 16-bit SRAM with a split data bus and byte strobes.
// Define B16_SRAM_ARB_RR_EN for round-robin arbitration; the default is fixed priority, port 0 first.
module b16_sram_arb #(
    parameter int unsigned l    = 16,
    parameter int unsigned WAIT = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req0,
    input  logic         req1,
    input  logic         we0,
    input  logic         we1,
    input  logic [1:0]   be0,
    input  logic [1:0]   be1,
    input  logic [l-1:0] addr0,
    input  logic [l-1:0] addr1,
    input  logic [l-1:0] wdata0,
    input  logic [l-1:0] wdata1,
    output logic         ack0,
    output logic         ack1,
    output logic [l-1:0] rdata,
    output logic [1:0]   gnt,
    output logic [l-1:0] sa,
    output logic [l-1:0] sd_o,
    input  logic [l-1:0] sd_i,
    output logic         sd_oe,
    output logic         rd_b,
    output logic         wr_b,
    output logic         ble_b,
    output logic         bhe_b
);

    typedef enum logic [1:0] {StIdle, StSetup, StStrobe, StRecover} state_e;

    state_e       state_q, state_d;
    logic [1:0]   gnt_q, gnt_d;
    logic         we_q, we_d;
    logic [1:0]   be_q, be_d;
    logic [l-1:0] addr_q, addr_d;
    logic [l-1:0] wdata_q, wdata_d;
    logic [l-1:0] rdata_q, rdata_d;
    logic [3:0]   cnt_q, cnt_d;
    logic         pick1;
    logic [l-1:0] byte_mask;

`ifdef B16_SRAM_ARB_RR_EN
    // pri_q names the port that wins the next simultaneous request.
    logic pri_q, pri_d;
    assign pick1 = req1 & (~req0 | pri_q);
`else
    assign pick1 = req1 & ~req0;
`endif

    assign byte_mask = {{(l - l / 2){be_q[1]}}, {(l / 2){be_q[0]}}};

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        we_d    = we_q;
        be_d    = be_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
`ifdef B16_SRAM_ARB_RR_EN
        pri_d   = pri_q;
`endif
        unique case (state_q)
            StIdle: begin
                gnt_d = 2'b00;
                if (req0 || req1) begin
                    state_d = StSetup;
                    gnt_d   = pick1 ? 2'b10 : 2'b01;
                    we_d    = pick1 ? we1 : we0;
                    be_d    = pick1 ? be1 : be0;
                    addr_d  = pick1 ? addr1 : addr0;
                    wdata_d = pick1 ? wdata1 : wdata0;
`ifdef B16_SRAM_ARB_RR_EN
                    pri_d   = ~pick1;
`endif
                end
            end
            StSetup: begin
                state_d = StStrobe;
                cnt_d   = 4'(WAIT);
            end
            StStrobe: begin
                if (cnt_q == 4'd0) begin
                    state_d = StRecover;
                    if (!we_q) begin
                        rdata_d = sd_i & byte_mask;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StRecover: begin
                state_d = StIdle;
                gnt_d   = 2'b00;
            end
            default: begin
                state_d = StIdle;
                gnt_d   = 2'b00;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            gnt_q   <= 2'b00;
            we_q    <= 1'b0;
            be_q    <= 2'b00;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= 4'd0;
`ifdef B16_SRAM_ARB_RR_EN
            pri_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            we_q    <= we_d;
            be_q    <= be_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
`ifdef B16_SRAM_ARB_RR_EN
            pri_q   <= pri_d;
`endif
        end
    end

    // Outputs decode from the state so a synchronous reset clears strobes on the next edge.
    always_comb begin
        ack0  = (state_q == StRecover) && gnt_q[0];
        ack1  = (state_q == StRecover) && gnt_q[1];
        gnt   = gnt_q;
        rdata = rdata_q;
        sa    = addr_q;
        sd_o  = wdata_q;
        sd_oe = (state_q != StIdle) && we_q;
        rd_b  = ~((state_q == StStrobe) && !we_q && (be_q != 2'b00));
        wr_b  = ~((state_q == StStrobe) && we_q && (be_q != 2'b00));
        ble_b = ~((state_q == StStrobe) && be_q[0]);
        bhe_b = ~((state_q == StStrobe) && be_q[1]);
    end

endmodule

// File: tb/tb_b16_sram_arb.sv
// Scoreboard bench for b16_sram_arb: each request pushes the expected owner and rdata,
// and the ack monitor pops and compares them.
module tb_b16_sram_arb;

    localparam int unsigned L = 16;
    localparam int unsigned W = 1;

    logic         clk = 1'b0;
    logic         reset;
    logic         req0, req1, we0, we1;
    logic [1:0]   be0, be1;
    logic [L-1:0] addr0, addr1, wdata0, wdata1;
    logic         ack0, ack1;
    logic [L-1:0] rdata;
    logic [1:0]   gnt;
    logic [L-1:0] sa, sd_o, sd_i;
    logic         sd_oe, rd_b, wr_b, ble_b, bhe_b;

    always #5 clk = ~clk;

    b16_sram_arb #(.l(L), .WAIT(W)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1), .be0(be0), .be1(be1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata(rdata), .gnt(gnt),
        .sa(sa), .sd_o(sd_o), .sd_i(sd_i), .sd_oe(sd_oe),
        .rd_b(rd_b), .wr_b(wr_b), .ble_b(ble_b), .bhe_b(bhe_b)
    );

    typedef struct packed {
        logic        port;
        logic [15:0] rdata;
    } exp_t;

    exp_t        sb_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] last_rd = 16'h0000;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Ack monitor: every ack must match the oldest scoreboard entry.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (ack0 || ack1) begin
                check_eq("ack_onehot", 32'(ack0 & ack1), 32'd0);
                check_eq("ack_expected", 32'(sb_q.size() != 0), 32'd1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    check_eq("ack_port", 32'(ack1), 32'(e.port));
                    check_eq("ack_rdata", 32'(rdata), 32'(e.rdata));
                end
            end
        end
    end

    task automatic run_txn(input logic port, input logic we, input logic [1:0] be,
                           input logic [15:0] addr, input logic [15:0] wdata,
                           input logic [15:0] sdi);
        int   lat = 0;
        int   rd_lo = 0, wr_lo = 0, bh_lo = 0, bl_lo = 0, oe = 0, viol = 0;
        exp_t e;
        logic [15:0] m;
        m = {{8{be[1]}}, {8{be[0]}}};
        if (!we) last_rd = sdi & m;
        e.port  = port;
        e.rdata = last_rd;
        sb_q.push_back(e);
        sd_i = sdi;
        if (port) begin
            req1 = 1'b1; we1 = we; be1 = be; addr1 = addr; wdata1 = wdata;
        end else begin
            req0 = 1'b1; we0 = we; be0 = be; addr0 = addr; wdata0 = wdata;
        end
        for (int c = 1; c <= 20 && lat == 0; c++) begin
            tick;
            if (c == 1) begin
                check_eq("setup_gnt", 32'(gnt), port ? 32'd2 : 32'd1);
                check_eq("setup_sa", 32'(sa), 32'(addr));
                check_eq("setup_sd_o", 32'(sd_o), 32'(wdata));
                check_eq("setup_strobes", 32'({rd_b, wr_b, ble_b, bhe_b}), 32'hF);
                check_eq("setup_oe", 32'(sd_oe), 32'(we));
            end
            if (!rd_b) rd_lo++;
            if (!wr_b) wr_lo++;
            if (!bhe_b) bh_lo++;
            if (!ble_b) bl_lo++;
            if (sd_oe) oe++;
            if (sd_oe && !rd_b) viol++;
            if (ack0 || ack1) begin
                lat = c;
                check_eq("recover_sa", 32'(sa), 32'(addr));
                check_eq("recover_sd_o", 32'(sd_o), 32'(wdata));
                check_eq("recover_strobes", 32'({rd_b, wr_b, ble_b, bhe_b}), 32'hF);
            end
        end
        req0 = 1'b0;
        req1 = 1'b0;
        check_eq("latency", 32'(lat), 32'(W + 3));
        check_eq("rd_b_low", 32'(rd_lo), (!we && be != 2'b00) ? 32'(W + 1) : 32'd0);
        check_eq("wr_b_low", 32'(wr_lo), (we && be != 2'b00) ? 32'(W + 1) : 32'd0);
        check_eq("bhe_b_low", 32'(bh_lo), be[1] ? 32'(W + 1) : 32'd0);
        check_eq("ble_b_low", 32'(bl_lo), be[0] ? 32'(W + 1) : 32'd0);
        check_eq("sd_oe_cycles", 32'(oe), we ? 32'(W + 3) : 32'd0);
        check_eq("oe_rd_overlap", 32'(viol), 32'd0);
        tick;
        check_eq("idle_gnt", 32'(gnt), 32'd0);
    endtask

    initial begin
        int   acks;
        int   last_c;
        exp_t e;

        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0; be0 = 2'b00; be1 = 2'b00;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0; sd_i = '0;
        tick; tick; tick;
        check_eq("rst_gnt", 32'(gnt), 32'd0);
        check_eq("rst_ack", 32'({ack0, ack1}), 32'd0);
        check_eq("rst_rdata", 32'(rdata), 32'd0);
        check_eq("rst_sa", 32'(sa), 32'd0);
        check_eq("rst_sd_o", 32'(sd_o), 32'd0);
        check_eq("rst_sd_oe", 32'(sd_oe), 32'd0);
        check_eq("rst_strobes", 32'({rd_b, wr_b, ble_b, bhe_b}), 32'hF);
        reset = 1'b0;
        tick;

        run_txn(1'b0, 1'b0, 2'b11, 16'h0123, 16'h0000, 16'hBEEF);
        run_txn(1'b1, 1'b1, 2'b10, 16'h0040, 16'hA55A, 16'h0000);
        run_txn(1'b0, 1'b0, 2'b01, 16'h0099, 16'h1111, 16'h1234);
        run_txn(1'b1, 1'b0, 2'b00, 16'h0077, 16'h2222, 16'hFFFF);
        run_txn(1'b0, 1'b1, 2'b01, 16'h0055, 16'h3C3C, 16'h0000);

        // Both ports request continuously.
        sd_i = 16'h5A5A;
        we0 = 1'b0; we1 = 1'b0; be0 = 2'b11; be1 = 2'b11;
        addr0 = 16'h0100; addr1 = 16'h0200;
        last_rd = 16'h5A5A;
        for (int i = 0; i < 4; i++) begin
`ifdef B16_SRAM_ARB_RR_EN
            e.port = (i % 2) == 1;
`else
            e.port = 1'b0;
`endif
            e.rdata = 16'h5A5A;
            sb_q.push_back(e);
        end
        req0 = 1'b1; req1 = 1'b1;
        acks = 0;
        last_c = 0;
        for (int c = 1; c <= 100 && acks < 4; c++) begin
            tick;
            if (ack0 || ack1) begin
                if (acks > 0) check_eq("ack_spacing", 32'(c - last_c), 32'(W + 4));
                acks++;
                last_c = c;
                if (acks == 4) begin
                    req0 = 1'b0;
                    req1 = 1'b0;
                end
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        check_eq("contend_acks", 32'(acks), 32'd4);
        tick;
        check_eq("contend_idle", 32'(gnt), 32'd0);

        // Reset in the middle of a write strobe.
        req0 = 1'b1; we0 = 1'b1; be0 = 2'b11; addr0 = 16'h0777; wdata0 = 16'hCAFE;
        tick;
        tick;
        check_eq("mid_wr_b", 32'(wr_b), 32'd0);
        check_eq("mid_sd_oe", 32'(sd_oe), 32'd1);
        reset = 1'b1;
        req0 = 1'b0;
        tick;
        check_eq("rstmid_wr_b", 32'(wr_b), 32'd1);
        check_eq("rstmid_sd_oe", 32'(sd_oe), 32'd0);
        check_eq("rstmid_gnt", 32'(gnt), 32'd0);
        check_eq("rstmid_rdata", 32'(rdata), 32'd0);
        last_rd = 16'h0000;
        reset = 1'b0;
        acks = 0;
        for (int c = 0; c < 8; c++) begin
            tick;
            if (ack0 || ack1) acks++;
        end
        check_eq("rstmid_no_ack", 32'(acks), 32'd0);

        run_txn(1'b1, 1'b0, 2'b10, 16'h0300, 16'h0000, 16'hF00D);

        check_eq("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
